exe_muldiv: RTL and testbench

Iterative multiply/divide unit in the EXE stage. It consumes the operand registers produced by the ID/EXE pipeline register (readData1Out, readData2Out) and the decoded mul/div opcode. It produces a 64-bit HI/LO result. While an operation is in flight it asserts stall, so the hazard logic freezes PC, IF/ID and ID/EXE.

---
 rtl/exe_muldiv.sv | 158 +++++++++++++++
 tb/tb_exe_muldiv.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide unit for the EXE stage: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign-corrected on retirement.
module exe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;

    logic             req_div;
    logic             req_signed;
    logic             req_div_zero;
    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign req_div      = op[1];
    assign req_signed   = ~op[0];
    assign req_div_zero = req_div & (opB == '0);
    assign accept       = (state == IDLE) & start & ~flush;
    assign mag_a        = (req_signed & opA[WIDTH-1]) ? -opA : opA;
    assign mag_b        = (req_signed & opB[WIDTH-1]) ? -opB : opB;

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign stall = (state == RUN) | ((state == IDLE) & start & ~flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // acc is the multiply accumulator or the division partial remainder;
    // shreg holds the multiplier or the dividend that turns into the quotient.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH:0]   acc_iter;
    logic [WIDTH-1:0] shreg_iter;

    always_comb begin
        mul_sum   = acc + (shreg[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (is_div) begin
            acc_iter   = div_ge ? div_diff : div_shift;
            shreg_iter = {shreg[WIDTH-2:0], div_ge};
        end else begin
            acc_iter   = {1'b0, mul_sum[WIDTH:1]};
            shreg_iter = {mul_sum[0], shreg[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        product = {acc_iter[WIDTH-1:0], shreg_iter};
        if (sign_a ^ sign_b) begin
            product = -product;
        end
        if (is_div) begin
            res_lo = (sign_a ^ sign_b) ? -shreg_iter : shreg_iter;
            res_hi = sign_a ? -acc_iter[WIDTH-1:0] : acc_iter[WIDTH-1:0];
        end else begin
            res_hi = product[2*WIDTH-1:WIDTH];
            res_lo = product[WIDTH-1:0];
        end
    end

    // Results are written on the edge that enters DONE; a flush on the final
    // iteration wins, so an abandoned op never touches hi/lo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            shreg  <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (accept) begin
                is_div <= req_div;
                sign_a <= req_signed & opA[WIDTH-1];
                sign_b <= req_signed & opB[WIDTH-1];
                acc    <= '0;
                shreg  <= req_div ? mag_a : mag_b;
                opnd   <= req_div ? mag_b : mag_a;
                count  <= '0;
                if (req_div_zero) begin
                    hi <= opA;
                    lo <= '1;
                end
            end else if ((state == RUN) && !flush) begin
                acc   <= acc_iter;
                shreg <= shreg_iter;
                count <= count + 1'b1;
                if (count == LAST) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed vector table, hand-written
// flush/reset sequences and randomized ops against an arithmetic reference model.
module tb_exe_muldiv;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             flush;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    exe_muldiv #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opA   (opA),
        .opB   (opB),
        .flush (flush),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on wide integers.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint      sa;
        longint      sb;
        longint      res;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        mh = '0;
        ml = '0;
        case (o)
            2'd0: begin
                p = sa * sb;
                {mh, ml} = p;
            end
            2'd1: begin
                p = {32'b0, a} * {32'b0, b};
                {mh, ml} = p;
            end
            2'd2: begin
                if (b == 0) begin
                    mh = a;
                    ml = '1;
                end else begin
                    res = sa / sb;
                    ml = res[31:0];
                    res = sa % sb;
                    mh = res[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    mh = a;
                    ml = '1;
                end else begin
                    ml = a / b;
                    mh = a % b;
                end
            end
        endcase
    endfunction

    // Issues one op, then follows it to done while scrambling the operand inputs.
    task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input int exp_lat);
        int lat = 0;
        int stall_low = 0;
        @(negedge clk);
        op = o;
        opA = a;
        opB = b;
        start = 1'b1;
        #1;
        checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
        if (!stall) stall_low++;
        do begin
            @(negedge clk);
            start = 1'b0;
            opA = $urandom;
            opB = $urandom;
            op = 2'($urandom);
            lat++;
            #1;
            if (!done && !stall) stall_low++;
        end while (!done && lat < 100);
        checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, " stall low cycles"}, 32'(stall_low), 32'd0);
        checkOutput({name, " stall in done"}, 32'(stall), 32'd0);
        checkOutput({name, " hi"}, hi, exp_hi);
        checkOutput({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] mh;
        logic [31:0] ml;
        int          stray;

        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'd0;
        opA = '0;
        opB = '0;
        #12;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back('{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33});
        vecs.push_back('{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33});
        vecs.push_back('{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33});
        vecs.push_back('{2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33});
        vecs.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
        vecs.push_back('{2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1});
        vecs.push_back('{2'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1});
        vecs.push_back('{2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33});
        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].hi, vecs[i].lo, vecs[i].lat);
        end

        // Flush during RUN, with an ignored start pulse in cycle 5.
        stray = 0;
        @(negedge clk);
        op = 2'd1;
        opA = 32'd3;
        opB = 32'd5;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = (c == 5);
            flush = (c == 10);
            #1;
            if (done) stray++;
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("flush run busy", 32'(busy), 32'd0);
        checkOutput("flush run hi", hi, 32'd2);
        checkOutput("flush run lo", lo, 32'd14);
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done || busy) stray++;
        end
        checkOutput("flush run no done", 32'(stray), 32'd0);

        // Flush and start together in IDLE.
        @(negedge clk);
        op = 2'd3;
        opA = 32'd100;
        opB = 32'd7;
        start = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("flush+start stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("flush+start busy", 32'(busy), 32'd0);

        // Flush in DONE: the op has already retired.
        @(negedge clk);
        op = 2'd3;
        opA = 32'd5;
        opB = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b1;
        #1;
        checkOutput("flush done pulse", 32'(done), 32'd1);
        checkOutput("flush done hi", hi, 32'd5);
        checkOutput("flush done lo", lo, 32'hFFFFFFFF);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush done busy", 32'(busy), 32'd0);
        checkOutput("flush done hold lo", lo, 32'hFFFFFFFF);

        // Asynchronous reset in the middle of an op.
        @(negedge clk);
        op = 2'd1;
        opA = 32'd3;
        opB = 32'd5;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(busy), 32'd0);
        checkOutput("async rst done", 32'(done), 32'd0);
        checkOutput("async rst hi", hi, 32'd0);
        checkOutput("async rst lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("mulu after rst", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 33);

        // Randomized ops against the reference model.
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            model(ro, ra, rb, mh, ml);
            applyStimulus($sformatf("rand%0d", i), ro, ra, rb, mh, ml,
                          (ro[1] && rb == 0) ? 1 : 33);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
